// File: rtl/i2c_target_byte.sv
// i2c_target_byte
// Byte-level I2C target that answers a master on the shared open-drain
// SCL/SDA lines. It recognises START, repeated START and STOP, matches a
// 7-bit address, hands written bytes to the core on a one-cycle strobe, and
// fetches read bytes through a valid/ready handshake. While it waits for
// read data it stretches the clock by holding SCL low.
//
// Ports
//   i_clk, i_rst          system clock, asynchronous active-high reset
//   i_scl, i_sda          sensed line levels (asynchronous to i_clk)
//   o_scl_drive           0 = pull SCL low, 1 = release
//   o_sda_drive           0 = pull SDA low, 1 = release
//   o_rx_valid, o_rx_data one-cycle strobe with the byte the master wrote
//   i_tx_valid, i_tx_data byte offered for the next master read
//   o_tx_ready            target takes i_tx_data when i_tx_valid is also high
//   o_busy                high from an address-matched START until STOP
//   o_rw                  R/W bit of the current matched transaction (1 = read)

module i2c_target_byte #(
    parameter logic [6:0] ADDR       = 7'h42,
    parameter int         FILTER_LEN = 3
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_scl_drive,
    output logic       o_sda_drive,
    output logic       o_rx_valid,
    output logic [7:0] o_rx_data,
    input  logic       i_tx_valid,
    input  logic [7:0] i_tx_data,
    output logic       o_tx_ready,
    output logic       o_busy,
    output logic       o_rw
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    typedef enum logic [3:0] {
        IDLE,
        ADDR_S,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_LOAD,
        RD_DATA,
        RD_ACK,
        WAIT_STOP
    } state_t;

    // Index 1 carries SCL, index 0 carries SDA through the conditioning path.
    logic [1:0]    lineIn;
    logic [1:0]    syncA_q;
    logic [1:0]    syncB_q;
    logic [1:0]    filt_q;
    logic [1:0]    prev_q;
    logic [CW-1:0] filtCnt_q [2];

    logic sclRise;
    logic sclFall;
    logic sclHigh;
    logic sdaIn;
    logic startCond;
    logic stopCond;

    state_t     state_q,    state_d;
    logic [7:0] shift_q,    shift_d;
    logic [7:0] txShift_q,  txShift_d;
    logic [3:0] bitCnt_q,   bitCnt_d;
    logic       sdaDrive_q, sdaDrive_d;
    logic       sclDrive_q, sclDrive_d;
    logic       rxValid_q,  rxValid_d;
    logic [7:0] rxData_q,   rxData_d;
    logic       txReady_q,  txReady_d;
    logic       busy_q,     busy_d;
    logic       rw_q,       rw_d;

    assign lineIn = {i_scl, i_sda};

    // Two-flop synchronizer followed by a glitch filter: the filtered level
    // only follows the synchronized line once it has disagreed for
    // FILTER_LEN consecutive samples. The idle bus is high, so everything
    // resets to 1 to avoid a spurious edge after reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            syncA_q <= 2'b11;
            syncB_q <= 2'b11;
            filt_q  <= 2'b11;
            prev_q  <= 2'b11;
            for (int i = 0; i < 2; i++) begin
                filtCnt_q[i] <= '0;
            end
        end else begin
            syncA_q <= lineIn;
            syncB_q <= syncA_q;
            prev_q  <= filt_q;
            for (int i = 0; i < 2; i++) begin
                if (syncB_q[i] == filt_q[i]) begin
                    filtCnt_q[i] <= '0;
                end else if (filtCnt_q[i] == CW'(FILTER_LEN - 1)) begin
                    filt_q[i]    <= syncB_q[i];
                    filtCnt_q[i] <= '0;
                end else begin
                    filtCnt_q[i] <= filtCnt_q[i] + 1'b1;
                end
            end
        end
    end

    // START/STOP need SCL to have been high on both the current and the
    // previous filtered sample, so an SDA change that lands together with an
    // SCL edge is never mistaken for a bus condition.
    assign sclRise   =  filt_q[1] & ~prev_q[1];
    assign sclFall   = ~filt_q[1] &  prev_q[1];
    assign sclHigh   =  filt_q[1] &  prev_q[1];
    assign sdaIn     =  filt_q[0];
    assign startCond = ~filt_q[0] &  prev_q[0] & sclHigh;
    assign stopCond  =  filt_q[0] & ~prev_q[0] & sclHigh;

    // State and datapath registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            txShift_q  <= '0;
            bitCnt_q   <= '0;
            sdaDrive_q <= 1'b1;
            sclDrive_q <= 1'b1;
            rxValid_q  <= 1'b0;
            rxData_q   <= '0;
            txReady_q  <= 1'b0;
            busy_q     <= 1'b0;
            rw_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            txShift_q  <= txShift_d;
            bitCnt_q   <= bitCnt_d;
            sdaDrive_q <= sdaDrive_d;
            sclDrive_q <= sclDrive_d;
            rxValid_q  <= rxValid_d;
            rxData_q   <= rxData_d;
            txReady_q  <= txReady_d;
            busy_q     <= busy_d;
            rw_q       <= rw_d;
        end
    end

    // Next-state logic. Bus conditions override whatever byte phase is in
    // progress, which also drops a partially received byte on a repeated
    // START and ends any clock stretch.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        txShift_d  = txShift_q;
        bitCnt_d   = bitCnt_q;
        sdaDrive_d = sdaDrive_q;
        sclDrive_d = sclDrive_q;
        rxValid_d  = 1'b0;
        rxData_d   = rxData_q;
        txReady_d  = txReady_q;
        busy_d     = busy_q;
        rw_d       = rw_q;

        if (startCond) begin
            state_d    = ADDR_S;
            bitCnt_d   = '0;
            sdaDrive_d = 1'b1;
            sclDrive_d = 1'b1;
            txReady_d  = 1'b0;
            busy_d     = 1'b0;
        end else if (stopCond) begin
            state_d    = IDLE;
            bitCnt_d   = '0;
            sdaDrive_d = 1'b1;
            sclDrive_d = 1'b1;
            txReady_d  = 1'b0;
            busy_d     = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    sdaDrive_d = 1'b1;
                    sclDrive_d = 1'b1;
                end

                // The address byte is complete on the 8th rise; shift_q then
                // still holds the seven address bits and sdaIn is R/W.
                ADDR_S: begin
                    if (sclRise && bitCnt_q < 4'd8) begin
                        shift_d  = {shift_q[6:0], sdaIn};
                        bitCnt_d = bitCnt_q + 4'd1;
                        if (bitCnt_q == 4'd7) begin
                            if (shift_q[6:0] == ADDR) begin
                                rw_d   = sdaIn;
                                busy_d = 1'b1;
                            end else begin
                                state_d = WAIT_STOP;
                            end
                        end
                    end else if (sclFall && bitCnt_q == 4'd8) begin
                        sdaDrive_d = 1'b0;
                        state_d    = ADDR_ACK;
                    end
                end

                // A read starts stretching immediately so the core has time
                // to supply the first byte.
                ADDR_ACK: begin
                    if (sclFall) begin
                        sdaDrive_d = 1'b1;
                        bitCnt_d   = '0;
                        if (rw_q) begin
                            state_d    = RD_LOAD;
                            sclDrive_d = 1'b0;
                            txReady_d  = 1'b1;
                        end else begin
                            state_d = WR_DATA;
                        end
                    end
                end

                WR_DATA: begin
                    if (sclRise && bitCnt_q < 4'd8) begin
                        shift_d  = {shift_q[6:0], sdaIn};
                        bitCnt_d = bitCnt_q + 4'd1;
                        if (bitCnt_q == 4'd7) begin
                            rxData_d  = {shift_q[6:0], sdaIn};
                            rxValid_d = 1'b1;
                        end
                    end else if (sclFall && bitCnt_q == 4'd8) begin
                        sdaDrive_d = 1'b0;
                        state_d    = WR_ACK;
                    end
                end

                WR_ACK: begin
                    if (sclFall) begin
                        sdaDrive_d = 1'b1;
                        bitCnt_d   = '0;
                        state_d    = WR_DATA;
                    end
                end

                // SCL is held low here, so putting the MSB on SDA at the
                // handshake is still a change during the low phase.
                RD_LOAD: begin
                    if (i_tx_valid && txReady_q) begin
                        txShift_d  = i_tx_data;
                        sdaDrive_d = i_tx_data[7];
                        txReady_d  = 1'b0;
                        sclDrive_d = 1'b1;
                        bitCnt_d   = 4'd1;
                        state_d    = RD_DATA;
                    end
                end

                // bitCnt_q counts bits already presented; the fall after the
                // eighth bit hands SDA back to the master for its ACK.
                RD_DATA: begin
                    if (sclFall) begin
                        if (bitCnt_q == 4'd8) begin
                            sdaDrive_d = 1'b1;
                            bitCnt_d   = '0;
                            state_d    = RD_ACK;
                        end else begin
                            sdaDrive_d = txShift_q[6];
                            txShift_d  = {txShift_q[6:0], 1'b0};
                            bitCnt_d   = bitCnt_q + 4'd1;
                        end
                    end
                end

                // bitCnt_q == 1 marks that an ACK was seen on this clock.
                RD_ACK: begin
                    if (sclRise) begin
                        if (sdaIn) begin
                            state_d = WAIT_STOP;
                        end else begin
                            bitCnt_d = 4'd1;
                        end
                    end else if (sclFall && bitCnt_q == 4'd1) begin
                        bitCnt_d   = '0;
                        sclDrive_d = 1'b0;
                        txReady_d  = 1'b1;
                        state_d    = RD_LOAD;
                    end
                end

                WAIT_STOP: begin
                    sdaDrive_d = 1'b1;
                    sclDrive_d = 1'b1;
                    txReady_d  = 1'b0;
                end

                default: begin
                    state_d    = IDLE;
                    sdaDrive_d = 1'b1;
                    sclDrive_d = 1'b1;
                    txReady_d  = 1'b0;
                end
            endcase
        end
    end

    assign o_scl_drive = sclDrive_q;
    assign o_sda_drive = sdaDrive_q;
    assign o_rx_valid  = rxValid_q;
    assign o_rx_data   = rxData_q;
    assign o_tx_ready  = txReady_q;
    assign o_busy      = busy_q;
    assign o_rw        = rw_q;

endmodule

// File: tb/tb_i2c_target_byte.sv
// tb_i2c_target_byte
// Bench for i2c_target_byte. A behavioural I2C master drives the open-drain
// bus (wired-AND with the target's drives); write transactions come from a
// table of vectors, and reads, repeated START, glitch rejection and reset
// are hand-written sequences.

module tb_i2c_target_byte;

    localparam int H = 20;

    logic       clk;
    logic       rst;
    logic       sclM;
    logic       sdaM;
    logic       txValid;
    logic [7:0] txData;
    logic       sclDrive;
    logic       sdaDrive;
    logic       rxValid;
    logic [7:0] rxData;
    logic       txReady;
    logic       busy;
    logic       rw;
    logic       sclLine;
    logic       sdaLine;

    int         testsRun;
    int         testsFailed;
    int         rxCount;
    int         sdaLowCount;
    int         hsCount;
    logic [7:0] rxLog [16];

    typedef struct {
        logic [7:0] addrByte;
        logic [7:0] data0;
        logic [7:0] data1;
        bit         expAck;
        int         expRx;
    } wrVec_t;

    wrVec_t vecs [5];

    assign sclLine = sclM & sclDrive;
    assign sdaLine = sdaM & sdaDrive;

    i2c_target_byte dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_scl       (sclLine),
        .i_sda       (sdaLine),
        .o_scl_drive (sclDrive),
        .o_sda_drive (sdaDrive),
        .o_rx_valid  (rxValid),
        .o_rx_data   (rxData),
        .i_tx_valid  (txValid),
        .i_tx_data   (txData),
        .o_tx_ready  (txReady),
        .o_busy      (busy),
        .o_rw        (rw)
    );

    // Free-running system clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bus monitors: collect written bytes, count cycles the target pulls SDA
    // low and count completed tx handshakes.
    always @(posedge clk) begin
        if (rst) begin
            rxCount     <= 0;
            sdaLowCount <= 0;
            hsCount     <= 0;
        end else begin
            if (rxValid) begin
                rxLog[rxCount[3:0]] <= rxData;
                rxCount             <= rxCount + 1;
            end
            if (!sdaDrive) sdaLowCount <= sdaLowCount + 1;
            if (txReady && txValid) hsCount <= hsCount + 1;
        end
    end

    // Hard stop in case something upstream hangs in an unexpected way.
    initial begin
        #800000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic reportTimeout(input string name);
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL %s: timed out, got no event expected event", name);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Release SCL and wait (bounded) for the target to stop stretching.
    task automatic releaseScl();
        bit seen;
        seen = 1'b0;
        sclM = 1'b1;
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (sclLine) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) reportTimeout("sclRelease");
    endtask

    task automatic startCond();
        sdaM = 1'b1;
        waitCycles(H);
        releaseScl();
        waitCycles(H);
        sdaM = 1'b0;
        waitCycles(H);
        sclM = 1'b0;
        waitCycles(H);
    endtask

    task automatic stopCond();
        sdaM = 1'b0;
        waitCycles(H);
        releaseScl();
        waitCycles(H);
        sdaM = 1'b1;
        waitCycles(H);
    endtask

    task automatic sendBit(input logic b);
        sdaM = b;
        waitCycles(H);
        releaseScl();
        waitCycles(H);
        sclM = 1'b0;
        waitCycles(4);
    endtask

    task automatic sampleBit(output logic b);
        sdaM = 1'b1;
        waitCycles(H);
        releaseScl();
        waitCycles(H / 2);
        b = sdaLine;
        waitCycles(H / 2);
        sclM = 1'b0;
        waitCycles(4);
    endtask

    task automatic writeByte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) sendBit(b[i]);
        sampleBit(ack);
    endtask

    task automatic readByte(input logic nack, output logic [7:0] b);
        for (int i = 7; i >= 0; i--) sampleBit(b[i]);
        sendBit(nack);
    endtask

    // Applies one write-vector transaction and checks its outcome.
    task automatic applyStimulus(input wrVec_t v, input int idx);
        logic ack;
        int   rxBase;
        int   lowBase;
        rxBase  = rxCount;
        lowBase = sdaLowCount;
        startCond();
        writeByte(v.addrByte, ack);
        checkOutput($sformatf("v%0d addrAck", idx), ack, v.expAck ? 0 : 1);
        checkOutput($sformatf("v%0d busy", idx), busy, v.expAck);
        if (v.expAck) checkOutput($sformatf("v%0d rw", idx), rw, 0);
        writeByte(v.data0, ack);
        checkOutput($sformatf("v%0d data0Ack", idx), ack, v.expAck ? 0 : 1);
        writeByte(v.data1, ack);
        checkOutput($sformatf("v%0d data1Ack", idx), ack, v.expAck ? 0 : 1);
        stopCond();
        waitCycles(20);
        checkOutput($sformatf("v%0d busyAfterStop", idx), busy, 0);
        checkOutput($sformatf("v%0d rxCount", idx), rxCount - rxBase, v.expRx);
        if (v.expRx == 2) begin
            checkOutput($sformatf("v%0d rxByte0", idx), rxLog[rxBase[3:0]], v.data0);
            checkOutput($sformatf("v%0d rxByte1", idx), rxLog[4'(rxBase + 1)], v.data1);
        end
        if (!v.expAck) begin
            checkOutput($sformatf("v%0d sdaNeverLow", idx), sdaLowCount - lowBase, 0);
        end
    endtask

    logic [7:0] rdByte0;
    logic [7:0] rdByte1;
    int         stretchLow;
    bit         seenReady;

    // Serves the two read bytes: the first after a 40-cycle delay, the
    // second already valid when the target asks for it.
    task automatic txDriver();
        seenReady = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (txReady) begin
                seenReady = 1'b1;
                break;
            end
        end
        if (!seenReady) reportTimeout("txReady1");
        stretchLow = 0;
        repeat (40) begin
            @(negedge clk);
            if (!sclDrive) stretchLow++;
        end
        txData  = 8'hC3;
        txValid = 1'b1;
        @(negedge clk);
        txData = 8'h18;
        seenReady = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (txReady) begin
                seenReady = 1'b1;
                break;
            end
        end
        if (!seenReady) reportTimeout("txReady2");
        @(negedge clk);
        txValid = 1'b0;
    endtask

    initial begin
        logic ack;
        int   base;
        testsRun    = 0;
        testsFailed = 0;
        rst     = 1'b1;
        sclM    = 1'b1;
        sdaM    = 1'b1;
        txValid = 1'b0;
        txData  = 8'h00;

        vecs[0] = '{8'h84, 8'hA5, 8'h3C, 1'b1, 2};
        vecs[1] = '{8'h86, 8'h55, 8'h00, 1'b0, 0};
        vecs[2] = '{8'h84, 8'h00, 8'hFF, 1'b1, 2};
        vecs[3] = '{8'h04, 8'h12, 8'h34, 1'b0, 0};
        vecs[4] = '{8'hC4, 8'h81, 8'h7E, 1'b0, 0};

        // Reset values.
        waitCycles(5);
        checkOutput("rstSclDrive", sclDrive, 1);
        checkOutput("rstSdaDrive", sdaDrive, 1);
        checkOutput("rstRxValid", rxValid, 0);
        checkOutput("rstRxData", rxData, 0);
        checkOutput("rstTxReady", txReady, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstRw", rw, 0);
        rst = 1'b0;
        waitCycles(10);

        // Table-driven write transactions.
        for (int i = 0; i < 5; i++) applyStimulus(vecs[i], i);

        // Read with clock stretching, master ACK then NACK.
        base = hsCount;
        startCond();
        writeByte(8'h85, ack);
        checkOutput("rdAddrAck", ack, 0);
        checkOutput("rdRw", rw, 1);
        fork
            txDriver();
            begin
                readByte(1'b0, rdByte0);
                readByte(1'b1, rdByte1);
            end
        join
        checkOutput("rdByte0", rdByte0, 8'hC3);
        checkOutput("rdByte1", rdByte1, 8'h18);
        checkOutput("rdStretchLow", stretchLow, 40);
        checkOutput("rdHandshakes", hsCount - base, 2);
        waitCycles(30);
        checkOutput("rdWaitStopReady", txReady, 0);
        checkOutput("rdWaitStopScl", sclDrive, 1);
        checkOutput("rdWaitStopSda", sdaDrive, 1);
        stopCond();
        waitCycles(20);
        checkOutput("rdBusyAfterStop", busy, 0);

        // Repeated START mid-byte, then a read served immediately.
        base    = rxCount;
        txData  = 8'h5A;
        txValid = 1'b1;
        startCond();
        writeByte(8'h84, ack);
        checkOutput("rsAddrAck", ack, 0);
        sendBit(1'b1);
        sendBit(1'b0);
        sendBit(1'b1);
        sendBit(1'b0);
        startCond();
        writeByte(8'h85, ack);
        checkOutput("rsReadAddrAck", ack, 0);
        checkOutput("rsRw", rw, 1);
        checkOutput("rsBusy", busy, 1);
        readByte(1'b1, rdByte0);
        txValid = 1'b0;
        checkOutput("rsReadByte", rdByte0, 8'h5A);
        stopCond();
        waitCycles(20);
        checkOutput("rsNoRxValid", rxCount - base, 0);

        // Short SDA pulses with SCL high must not look like a START.
        base = sdaLowCount;
        @(negedge clk) sdaM = 1'b0;
        @(negedge clk) sdaM = 1'b1;
        waitCycles(20);
        @(negedge clk) sdaM = 1'b0;
        waitCycles(2);
        sdaM = 1'b1;
        waitCycles(20);
        sclM = 1'b0;
        waitCycles(H);
        writeByte(8'h84, ack);
        checkOutput("glitchNoAck", ack, 1);
        checkOutput("glitchBusy", busy, 0);
        checkOutput("glitchSdaNeverLow", sdaLowCount - base, 0);
        stopCond();
        waitCycles(20);

        // Reset while the target is holding the address ACK.
        startCond();
        for (int i = 7; i >= 0; i--) sendBit(base[0] | 1'b1 ? 1'b0 : 1'b0);
        rst = 1'b0;
        stopCond();
        waitCycles(20);
        startCond();
        begin
            logic [7:0] a;
            a = 8'h84;
            for (int i = 7; i >= 0; i--) sendBit(a[i]);
        end
        sdaM = 1'b1;
        seenReady = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!sdaDrive) begin
                seenReady = 1'b1;
                break;
            end
        end
        if (!seenReady) reportTimeout("ackDriveBeforeReset");
        rst = 1'b1;
        #1;
        checkOutput("rstMidSdaDrive", sdaDrive, 1);
        checkOutput("rstMidSclDrive", sclDrive, 1);
        checkOutput("rstMidBusy", busy, 0);
        waitCycles(2);
        rst = 1'b0;
        sclM = 1'b1;
        waitCycles(50);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
